sysid_read_arbiter: RTL and testbench
=====================================

SYSID_READ_ARBITER -- requirements
Module: sysid_read_arbiter

Interface
REQ-001 SHALL have parameter: EXPECTED_TIMESTAMP, 32'h569D6443, value the sysid slave must return at word 1.
REQ-002 SHALL have port: clock  in  1  single clock; all state updates on its rising edge.
REQ-003 SHALL have port: reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port: m0_req  in  1  requester 0 read request, level, held until m0_valid.
REQ-005 SHALL have port: m0_address  in  1  requester 0 word select, stable while m0_req high.
REQ-006 SHALL have port: m0_valid  out  1  one-cycle pulse, rdata holds requester 0 result.
REQ-007 SHALL have ports m1_req, m1_address, m1_valid, identical in meaning to REQ-004..006 for requester 1.
REQ-008 SHALL have port: rdata  out  32  registered read result, shared by both requesters.
REQ-009 SHALL have port: sid_address  out  1  address to sysid slave (combinational, zero-latency readdata).
REQ-010 SHALL have port: sid_readdata  in  32  sysid slave read data.
REQ-011 SHALL have port: id_ok  out  1  sticky, boot check passed.
REQ-012 SHALL have port: id_err  out  1  sticky, any word-1 read differed from EXPECTED_TIMESTAMP.

Function
REQ-013 SHALL implement states BOOT, IDLE, READ, DONE.
REQ-014 BOOT (one cycle): sid_address=1; at edge, sid_readdata==EXPECTED_TIMESTAMP sets id_ok, otherwise sets id_err; next state IDLE.
REQ-015 SHALL ignore requests in BOOT; requests held across BOOT are served from IDLE.
REQ-016 IDLE: sid_address=0; if no req, stay; if any req, latch owner and its address, next state READ.
REQ-017 Arbitration: single req wins; both high -> grant the requester not granted last; last_grant resets to 1 so m0 wins the first tie.
REQ-018 READ: sid_address=latched address; at edge rdata<=sid_readdata, owner valid<=1, next state DONE.
REQ-019 DONE: owner valid high for exactly this cycle, sid_address=0; next state IDLE.
REQ-020 Latency: req sampled at IDLE edge k -> valid high during cycle k+2; one read per 3 cycles max.
REQ-021 Requester SHALL drop req at the edge ending its valid cycle; req still high then is a new request.
REQ-022 m0_valid and m1_valid SHALL never both be high.
REQ-023 rdata SHALL hold last captured value until next READ capture.
REQ-024 Serviced reads at address 1 returning value != EXPECTED_TIMESTAMP SHALL set id_err; id_ok is not cleared.
REQ-025 id_ok and id_err SHALL clear only on reset.
REQ-026 Request address change while req high SHALL not alter a latched in-flight read.

Reset
REQ-027 reset high SHALL immediately force state BOOT, m0_valid=0, m1_valid=0, rdata=0, id_ok=0, id_err=0, last_grant=1; sid_address SHALL be 1 while in BOOT.
REQ-028 Reset during READ or DONE SHALL drop the in-flight read with no valid pulse; BOOT check re-runs after release.

Verification
REQ-029 Slave model returns 0x569D6443 at addr 1, 0 at addr 0; release reset -> id_ok=1 after BOOT cycle, id_err=0.
REQ-030 Model returns 0x12345678 at addr 1 -> id_err=1, id_ok=0, both unchanged over 100 idle cycles.
REQ-031 m0_req=1, m0_address=1 in IDLE -> sid_address=1 in READ only, m0_valid pulse 2 cycles later, rdata=0x569D6443, m1_valid=0.
REQ-032 m0_req and m1_req held continuously -> valid pulses alternate m0,m1,m0,m1 at 3-cycle spacing.
REQ-033 Reset asserted mid-READ for m1 -> no m1_valid, all outputs 0 at once, BOOT re-check on release.
REQ-034 m1_req raised during BOOT -> m1 served first in IDLE, m1_valid 2 cycles after entering IDLE.

Source files
------------

// File: rtl/sysid_read_arbiter.sv
// Two-requester arbiter in front of a zero-latency sysid slave; boot-time timestamp check.
// Latency: request sampled at an IDLE edge gives valid two cycles later; new grants are refused while a read is in flight.
module sysid_read_arbiter #(
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'h569D6443
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        m0_req,
   input  logic        m0_address,
   output logic        m0_valid,
   input  logic        m1_req,
   input  logic        m1_address,
   output logic        m1_valid,
   output logic [31:0] rdata,
   output logic        sid_address,
   input  logic [31:0] sid_readdata,
   output logic        id_ok,
   output logic        id_err
);

   typedef enum logic [1:0] {BOOT, IDLE, READ, DONE} state_t;

   state_t      r_state;
   logic        r_owner;
   logic        r_addr;
   logic        r_last_grant;
   logic        r_m0_valid;
   logic        r_m1_valid;
   logic        r_id_ok;
   logic        r_id_err;
   logic [31:0] r_rdata;

   logic        w_grant_m1;
   logic        w_ts_match;

   // r_last_grant high means m1 was served last, so m0 wins the next tie.
   assign w_grant_m1 = m1_req & (~m0_req | ~r_last_grant);
   assign w_ts_match = (sid_readdata == EXPECTED_TIMESTAMP);

   assign m0_valid = r_m0_valid;
   assign m1_valid = r_m1_valid;
   assign rdata    = r_rdata;
   assign id_ok    = r_id_ok;
   assign id_err   = r_id_err;

   always_comb begin
      sid_address = 1'b0;
      case (r_state)
         BOOT:    sid_address = 1'b1;
         READ:    sid_address = r_addr;
         default: sid_address = 1'b0;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state      <= BOOT;
         r_owner      <= 1'b0;
         r_addr       <= 1'b0;
         r_last_grant <= 1'b1;
         r_m0_valid   <= 1'b0;
         r_m1_valid   <= 1'b0;
         r_id_ok      <= 1'b0;
         r_id_err     <= 1'b0;
         r_rdata      <= 32'h0;
      end else begin
         r_m0_valid <= 1'b0;
         r_m1_valid <= 1'b0;
         case (r_state)
            BOOT: begin
               if (w_ts_match) r_id_ok  <= 1'b1;
               else            r_id_err <= 1'b1;
               r_state <= IDLE;
            end
            IDLE: begin
               if (m0_req || m1_req) begin
                  r_owner      <= w_grant_m1;
                  r_last_grant <= w_grant_m1;
                  r_addr       <= w_grant_m1 ? m1_address : m0_address;
                  r_state      <= READ;
               end
            end
            READ: begin
               r_rdata <= sid_readdata;
               if (r_owner) r_m1_valid <= 1'b1;
               else         r_m0_valid <= 1'b1;
               if (r_addr && !w_ts_match) r_id_err <= 1'b1;
               r_state <= DONE;
            end
            DONE: r_state <= IDLE;
            default: r_state <= BOOT;
         endcase
      end
   end

endmodule

// File: tb/tb_sysid_read_arbiter.sv
// Scoreboarded bench: per-requester expected-data queues filled at request time, drained by a valid monitor.
module tb_sysid_read_arbiter;

   localparam logic [31:0] EXP_TS = 32'h569D6443;
   localparam logic [31:0] BAD_TS = 32'h12345678;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        m0_req = 1'b0, m0_address = 1'b0;
   logic        m1_req = 1'b0, m1_address = 1'b0;
   logic        m0_valid, m1_valid, sid_address, id_ok, id_err;
   logic [31:0] rdata, sid_readdata;
   logic [31:0] ts_value = EXP_TS;

   int checks = 0;
   int failures = 0;
   logic [31:0] q0[$];
   logic [31:0] q1[$];

   always #5 clock = ~clock;

   // Behavioural sysid slave: word 1 is the timestamp, word 0 reads zero.
   assign sid_readdata = sid_address ? ts_value : 32'h0;

   sysid_read_arbiter #(.EXPECTED_TIMESTAMP(EXP_TS)) dut (
      .clock(clock), .reset(reset),
      .m0_req(m0_req), .m0_address(m0_address), .m0_valid(m0_valid),
      .m1_req(m1_req), .m1_address(m1_address), .m1_valid(m1_valid),
      .rdata(rdata), .sid_address(sid_address), .sid_readdata(sid_readdata),
      .id_ok(id_ok), .id_err(id_err)
   );

   function automatic logic [31:0] slave(input logic a);
      return a ? ts_value : 32'h0;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic chkb(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clock);
      #1;
   endtask

   task automatic samp();
      @(negedge clock);
   endtask

   task automatic chk_reset_outs(input string t);
      chkb({t, "_m0_valid"}, m0_valid, 1'b0);
      chkb({t, "_m1_valid"}, m1_valid, 1'b0);
      chk ({t, "_rdata"}, rdata, 32'h0);
      chkb({t, "_id_ok"}, id_ok, 1'b0);
      chkb({t, "_id_err"}, id_err, 1'b0);
      chkb({t, "_sid_addr"}, sid_address, 1'b1);
   endtask

   // Assert reset mid-cycle, release it, and step through BOOT; returns at the start of the first IDLE cycle.
   task automatic reset_and_boot(input string t);
      reset = 1'b1;
      #1;
      chk_reset_outs(t);
      cyc();
      reset = 1'b0;
      samp();
      chkb({t, "_boot_sid_addr"}, sid_address, 1'b1);
      chkb({t, "_boot_id_ok_pre"}, id_ok, 1'b0);
      cyc();
   endtask

   task automatic set_req(input bit who, input logic r, input logic a);
      if (who) begin m1_req = r; m1_address = a; end
      else     begin m0_req = r; m0_address = a; end
   endtask

   task automatic wait_valid(input bit who, output bit ok);
      ok = 1'b0;
      for (int c = 0; c < 20 && !ok; c++) begin
         samp();
         if (who ? m1_valid : m0_valid) ok = 1'b1;
      end
      chkb(who ? "m1_served" : "m0_served", ok, 1'b1);
   endtask

   task automatic requester(input bit who, input int n);
      bit   ok;
      bit   keep;
      logic a;
      keep = 1'b0;
      for (int k = 0; k < n; k++) begin
         if (!keep) repeat ($urandom_range(1, 4)) cyc();
         a = 1'($urandom_range(0, 1));
         set_req(who, 1'b1, a);
         if (who) q1.push_back(slave(a)); else q0.push_back(slave(a));
         wait_valid(who, ok);
         if (!ok) begin
            if (who) void'(q1.pop_back()); else void'(q0.pop_back());
         end
         cyc();
         keep = (k < n - 1) && ($urandom_range(0, 1) == 1);
         if (!keep) set_req(who, 1'b0, 1'b0);
      end
   endtask

   // Monitor: every valid pulse must match the oldest outstanding expectation of its requester.
   always @(negedge clock) begin
      if (m0_valid || m1_valid) begin
         chkb("one_hot_valid", m0_valid & m1_valid, 1'b0);
         if (m0_valid) begin
            chkb("m0_pending", q0.size() != 0, 1'b1);
            if (q0.size() != 0) chk("m0_rdata", rdata, q0.pop_front());
         end
         if (m1_valid) begin
            chkb("m1_pending", q1.size() != 0, 1'b1);
            if (q1.size() != 0) chk("m1_rdata", rdata, q1.pop_front());
         end
      end
   end

   initial begin
      #200000;
      failures++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1);
   end

   initial begin
      logic a0, a1;

      // Power-on boot with a good timestamp, then a single word-1 read by m0.
      ts_value = EXP_TS;
      reset_and_boot("por");
      m0_req = 1'b1; m0_address = 1'b1;
      q0.push_back(EXP_TS);
      samp();
      chkb("idle_sid_addr", sid_address, 1'b0);
      chkb("boot_id_ok", id_ok, 1'b1);
      chkb("boot_id_err", id_err, 1'b0);
      cyc();
      m0_address = 1'b0;  // must not disturb the latched read
      samp();
      chkb("read_sid_addr", sid_address, 1'b1);
      chkb("read_m0_valid", m0_valid, 1'b0);
      cyc();
      samp();
      chkb("done_m0_valid", m0_valid, 1'b1);
      chkb("done_m1_valid", m1_valid, 1'b0);
      chk ("done_rdata", rdata, EXP_TS);
      chkb("done_sid_addr", sid_address, 1'b0);
      cyc();
      m0_req = 1'b0;
      samp();
      chkb("post_m0_valid", m0_valid, 1'b0);
      chk ("rdata_hold", rdata, EXP_TS);
      cyc();

      // Both requesters held: m0 first after reset, then strict alternation every 3 cycles.
      reset_and_boot("alt");
      a0 = 1'($urandom_range(0, 1));
      a1 = 1'($urandom_range(0, 1));
      m0_req = 1'b1; m0_address = a0;
      m1_req = 1'b1; m1_address = a1;
      repeat (2) begin q0.push_back(slave(a0)); q1.push_back(slave(a1)); end
      for (int i = 0; i < 12; i++) begin
         samp();
         chkb($sformatf("alt_m0_c%0d", i), m0_valid, (i == 2) || (i == 8));
         chkb($sformatf("alt_m1_c%0d", i), m1_valid, (i == 5) || (i == 11));
         cyc();
      end
      m0_req = 1'b0; m1_req = 1'b0;
      cyc();

      // Randomised traffic from both requesters.
      fork
         requester(1'b0, 30);
         requester(1'b1, 30);
      join
      cyc();
      cyc();
      chk ("rand_q0_empty", q0.size(), 32'h0);
      chk ("rand_q1_empty", q1.size(), 32'h0);
      chkb("rand_id_ok", id_ok, 1'b1);
      chkb("rand_id_err", id_err, 1'b0);

      // Word-1 read returning a wrong timestamp after a good boot.
      ts_value = BAD_TS;
      m1_req = 1'b1; m1_address = 1'b1;
      q1.push_back(BAD_TS);
      begin
         bit ok;
         wait_valid(1'b1, ok);
      end
      cyc();
      m1_req = 1'b0;
      samp();
      chkb("late_id_err", id_err, 1'b1);
      chkb("late_id_ok_kept", id_ok, 1'b1);
      cyc();

      // Reset in the middle of an m1 read: dropped with no pulse.
      ts_value = EXP_TS;
      m1_req = 1'b1; m1_address = 1'b1;
      cyc();
      samp();
      chkb("midread_sid_addr", sid_address, 1'b1);
      #1;
      m1_req = 1'b0;
      reset_and_boot("midread");
      for (int i = 0; i < 4; i++) begin
         samp();
         chkb($sformatf("midread_no_m1_c%0d", i), m1_valid, 1'b0);
         if (i == 0) begin
            chkb("midread_reboot_ok", id_ok, 1'b1);
            chkb("midread_reboot_err", id_err, 1'b0);
         end
         cyc();
      end

      // m1 raises its request during BOOT and is served straight out of IDLE.
      reset = 1'b1;
      #1;
      chk_reset_outs("bootreq");
      cyc();
      reset = 1'b0;
      a1 = 1'($urandom_range(0, 1));
      m1_req = 1'b1; m1_address = a1;
      q1.push_back(slave(a1));
      samp();
      chkb("bootreq_boot_m1", m1_valid, 1'b0);
      for (int i = 0; i < 3; i++) begin
         cyc();
         samp();
         chkb($sformatf("bootreq_m1_c%0d", i), m1_valid, i == 2);
         chkb($sformatf("bootreq_m0_c%0d", i), m0_valid, 1'b0);
      end
      cyc();
      m1_req = 1'b0;

      // Bad timestamp at boot: sticky error, no ok, stable while idle.
      ts_value = BAD_TS;
      reset_and_boot("badboot");
      for (int i = 0; i < 100; i++) begin
         samp();
         if (i % 25 == 0 || i == 99) begin
            chkb($sformatf("badboot_id_err_c%0d", i), id_err, 1'b1);
            chkb($sformatf("badboot_id_ok_c%0d", i), id_ok, 1'b0);
         end
         cyc();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
